reg_share_arbiter: RTL and testbench

REG_SHARE_ARBITER -- requirements
Module: reg_share_arbiter

---
 rtl/reg_share_arbiter.sv | 143 ++++++++++++++
 tb/tb_reg_share_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_share_arbiter.sv
// Four-requester round-robin arbiter sharing one capture register.
// Each capture raises valid for HOLD cycles before the next arbitration.
module reg_share_arbiter #(
    parameter int WIDTH = 8,
    parameter int HOLD  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] d_in,
    output logic [3:0]         gnt,
    output logic [3:0]         ack,
    output logic [WIDTH-1:0]   q,
    output logic [WIDTH-1:0]   qb,
    output logic               valid,
    output logic               busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_HOLD
    } state_t;

    localparam logic [3:0] HOLD_INIT = 4'(HOLD - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [1:0]         r_ptr;
    logic [1:0]         r_win;
    logic [3:0]         r_cnt;
    logic [3:0]         r_gnt;
    logic [3:0]         r_ack;
    logic [WIDTH-1:0]   r_q;
    logic               r_valid;

    logic [1:0]         w_win;
    logic [1:0]         w_idx;
    logic               w_found;
    logic               w_capture;
    logic [WIDTH-1:0]   w_slice;

    // Round-robin search: first asserted request at or above r_ptr, mod 4.
    always_comb begin
        w_win   = r_ptr;
        w_idx   = '0;
        w_found = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            w_idx = r_ptr + 2'(i);
            if (!w_found && req[w_idx]) begin
                w_win   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_slice = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (r_win == 2'(i)) begin
                w_slice = d_in[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_next_state = S_GRANT;
                end
            end
            S_GRANT: begin
                w_capture    = req[r_win];
                w_next_state = req[r_win] ? S_HOLD : S_IDLE;
            end
            S_HOLD: begin
                if (r_cnt == '0) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= '0;
            r_win   <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_ack   <= '0;
            r_q     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_ack <= '0;
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_gnt <= 4'b0001 << w_win;
                        r_win <= w_win;
                    end
                end
                S_GRANT: begin
                    r_gnt <= '0;
                    if (w_capture) begin
                        r_q     <= w_slice;
                        r_ack   <= 4'b0001 << r_win;
                        r_valid <= 1'b1;
                        r_ptr   <= r_win + 2'd1;
                        r_cnt   <= HOLD_INIT;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == '0) begin
                        r_valid <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign gnt   = r_gnt;
    assign ack   = r_ack;
    assign q     = r_q;
    assign qb    = ~r_q;
    assign valid = r_valid;
    assign busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed bench for reg_share_arbiter (WIDTH=8, HOLD=2) with a capture scoreboard.
module tb_reg_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] d_in;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [7:0]  q;
    logic [7:0]  qb;
    logic        valid;
    logic        busy;

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } cap_t;

    cap_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    reg_share_arbiter #(.WIDTH(8), .HOLD(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .d_in  (d_in),
        .gnt   (gnt),
        .ack   (ack),
        .q     (q),
        .qb    (qb),
        .valid (valid),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int who, input logic [7:0] data);
        cap_t e;
        e.a = 4'b0001 << who;
        e.d = data;
        sb_q.push_back(e);
    endtask

    // Advance one edge, sample 1 time unit later, and retire any acked capture.
    task automatic tick();
        cap_t e;
        @(posedge clk);
        #1;
        if (ack !== 4'b0000) begin
            if (sb_q.size() == 0) begin
                chk("sb_spurious_ack", {28'd0, ack}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_ack", {28'd0, ack}, {28'd0, e.a});
                chk("sb_q", {24'd0, q}, {24'd0, e.d});
                chk("sb_valid", {31'd0, valid}, 32'd1);
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_slice(input int who, input logic [7:0] v);
        d_in[who*8 +: 8] = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        tick();
        rst = 1'b0;
    endtask

    int order [5] = '{0, 1, 2, 3, 0};
    int n_rise;
    int last_rise;
    logic [3:0] prev_gnt;

    initial begin
        rst  = 1'b1;
        req  = 4'b0000;
        d_in = '0;
        run(2);
        chk("rst_gnt", {28'd0, gnt}, 32'd0);
        chk("rst_ack", {28'd0, ack}, 32'd0);
        chk("rst_q", {24'd0, q}, 32'h00);
        chk("rst_qb", {24'd0, qb}, 32'hFF);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;

        // Single request
        set_slice(0, 8'hA5);
        req = 4'b0001;
        push(0, 8'hA5);
        tick();
        chk("single_gnt", {28'd0, gnt}, 32'h1);
        chk("single_busy", {31'd0, busy}, 32'd1);
        chk("single_ack_early", {28'd0, ack}, 32'd0);
        tick();
        req = 4'b0000;
        chk("single_gnt_off", {28'd0, gnt}, 32'd0);
        chk("single_qb", {24'd0, qb}, 32'h5A);
        tick();
        chk("single_ack_pulse", {28'd0, ack}, 32'd0);
        chk("single_valid2", {31'd0, valid}, 32'd1);
        chk("single_busy2", {31'd0, busy}, 32'd1);
        tick();
        chk("single_valid_end", {31'd0, valid}, 32'd0);
        chk("single_busy_end", {31'd0, busy}, 32'd0);

        // Round robin from ptr 0 with all requesters active
        do_reset();
        d_in = 32'h13121110;
        for (int i = 0; i < 5; i++) push(order[i], 8'h10 + 8'(order[i]));
        req = 4'b1111;
        n_rise = 0;
        last_rise = 0;
        prev_gnt = 4'b0000;
        for (int k = 0; k < 18; k++) begin
            tick();
            if (gnt !== 4'b0000 && prev_gnt === 4'b0000) begin
                if (n_rise < 5) chk("rr_gnt_order", {28'd0, gnt}, 32'd1 << order[n_rise]);
                if (n_rise > 0) chk("rr_spacing", k - last_rise, 32'd4);
                last_rise = k;
                n_rise++;
            end
            prev_gnt = gnt;
        end
        req = 4'b0000;
        run(2);
        chk("rr_grant_count", n_rise, 32'd5);
        chk("rr_idle", {31'd0, busy}, 32'd0);

        // Move ptr to 3 via a capture for requester 2, then fairness across the wrap
        do_reset();
        set_slice(2, 8'h22);
        req = 4'b0100;
        push(2, 8'h22);
        run(2);
        req = 4'b0000;
        run(2);
        set_slice(3, 8'h33);
        set_slice(0, 8'h30);
        req = 4'b1001;
        push(3, 8'h33);
        push(0, 8'h30);
        tick();
        chk("wrap_first_gnt", {28'd0, gnt}, 32'h8);
        run(3);
        tick();
        chk("wrap_second_gnt", {28'd0, gnt}, 32'h1);
        tick();
        req = 4'b0000;
        run(2);

        // Abort: requester 2 drops during GRANT (ptr is 1 here)
        req = 4'b0100;
        tick();
        chk("abort_gnt", {28'd0, gnt}, 32'h4);
        req = 4'b0000;
        tick();
        chk("abort_gnt_off", {28'd0, gnt}, 32'd0);
        chk("abort_q", {24'd0, q}, 32'h30);
        chk("abort_valid", {31'd0, valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        set_slice(2, 8'h44);
        req = 4'b0101;
        push(2, 8'h44);
        tick();
        chk("abort_ptr_kept", {28'd0, gnt}, 32'h4);
        tick();
        req = 4'b0000;
        run(2);

        // Reset in first HOLD cycle after capturing 0xFF (ptr is 3 here)
        set_slice(0, 8'hFF);
        req = 4'b0001;
        push(0, 8'hFF);
        tick();
        chk("rsthold_gnt", {28'd0, gnt}, 32'h1);
        tick();
        rst = 1'b1;
        req = 4'b0000;
        tick();
        rst = 1'b0;
        chk("rsthold_q", {24'd0, q}, 32'h00);
        chk("rsthold_qb", {24'd0, qb}, 32'hFF);
        chk("rsthold_valid", {31'd0, valid}, 32'd0);
        chk("rsthold_busy", {31'd0, busy}, 32'd0);
        set_slice(1, 8'h5C);
        req = 4'b0010;
        tick();
        chk("rsthold_regrant", {28'd0, gnt}, 32'h2);

        // Reset during GRANT discards the capture
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b0000;
        chk("rstgnt_gnt", {28'd0, gnt}, 32'd0);
        chk("rstgnt_q", {24'd0, q}, 32'h00);
        chk("rstgnt_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("rstgnt_no_ack", {28'd0, ack}, 32'd0);

        // Latecomer during HOLD waits for IDLE
        set_slice(0, 8'h77);
        set_slice(1, 8'h78);
        req = 4'b0001;
        push(0, 8'h77);
        run(2);
        req = 4'b0010;
        push(1, 8'h78);
        tick();
        chk("late_hold_gnt", {28'd0, gnt}, 32'd0);
        tick();
        chk("late_idle_gnt", {28'd0, gnt}, 32'd0);
        chk("late_idle_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("late_gnt", {28'd0, gnt}, 32'h2);
        tick();
        req = 4'b0000;
        run(2);

        chk("sb_drain", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
